// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard-unit enables, execute-stage redirect,
// instruction-memory port and the IF/ID outputs toward decode.
interface fetch_stage_if #(
    parameter int CNT_W = 16
);
    logic             pc_en;
    logic             ifid_en;
    logic             pc_src;
    logic [31:0]      branch_target;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_data;
    logic [31:0]      if_id_instr;
    logic [31:0]      if_id_pc4;
    logic             if_id_valid;
    logic [CNT_W-1:0] stall_count;

    // The surrounding pipeline (hazard unit, execute stage, instruction memory).
    modport master (
        output pc_en,
        output ifid_en,
        output pc_src,
        output branch_target,
        output imem_data,
        input  imem_addr,
        input  if_id_instr,
        input  if_id_pc4,
        input  if_id_valid,
        input  stall_count
    );

    // The fetch stage itself.
    modport slave (
        input  pc_en,
        input  ifid_en,
        input  pc_src,
        input  branch_target,
        input  imem_data,
        output imem_addr,
        output if_id_instr,
        output if_id_pc4,
        output if_id_valid,
        output stall_count
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the program counter and the IF/ID register,
// steered by hazard-unit enables and the execute-stage branch redirect.
module fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic         clk,
    input  logic         rst,
    fetch_stage_if.slave fs
);
    logic [31:0]      pc_q;
    logic [31:0]      pc_d;
    logic [31:0]      pc_plus4;
    logic [31:0]      redirect_pc;

    logic [31:0]      instr_q;
    logic [31:0]      instr_d;
    logic [31:0]      pc4_q;
    logic [31:0]      pc4_d;
    logic             valid_q;
    logic             valid_d;

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic             stall_edge;
    logic             cnt_sat;

    // Branch targets are word aligned; the low two bits are simply dropped.
    logic             unused_bt;
    assign unused_bt   = ^fs.branch_target[1:0];

    assign pc_plus4    = pc_q + 32'd4;
    assign redirect_pc = {fs.branch_target[31:2], 2'b00};
    assign stall_edge  = !fs.pc_src && !fs.pc_en;
    assign cnt_sat     = &stall_cnt_q;

    // A redirect wins over a freeze so a taken branch is never lost to a stall.
    always_comb begin
        pc_d = pc_q;
        if (fs.pc_src) begin
            pc_d = redirect_pc;
        end else if (fs.pc_en) begin
            pc_d = pc_plus4;
        end
    end

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (fs.pc_src) begin
            instr_d = NOP_WORD;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
        end else if (fs.ifid_en) begin
            instr_d = fs.imem_data;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_edge && !cnt_sat) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= PC_RESET;
            instr_q     <= NOP_WORD;
            pc4_q       <= 32'd0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pc4_q       <= pc4_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fs.imem_addr   = pc_q;
    assign fs.if_id_instr = instr_q;
    assign fs.if_id_pc4   = pc4_q;
    assign fs.if_id_valid = valid_q;
    assign fs.stall_count = stall_cnt_q;
endmodule
